apb_master_bridge: RTL and testbench

APB requester that converts a simple valid/ready command stream into APB transfers toward the UART peripheral's APB completer. Commands (write/read, 8-bit addr, 8-bit data) are queued in a small command FIFO. They are issued as SETUP/ACCESS phases, honouring PREADY. Each completed transfer produces a one-cycle response pulse carrying read data. Sits between a test sequencer or CPU-side logic and the UART register block.

---
 rtl/apb_master_pkg.sv | 22 ++
 rtl/apb_cmd_fifo.sv | 54 +++++
 rtl/apb_master_bridge.sv | 160 ++++++++++++++++
 tb/tb_apb_master_bridge.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared state encoding, bus widths and command word layout for the APB requester bridge.
package apb_master_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int CMD_W  = 1 + ADDR_W + DATA_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SETUP  = ST_SETUP,
    S_ACCESS = ST_ACCESS
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;
endpackage

// File: rtl/apb_cmd_fifo.sv
// Command queue, show-ahead read: head entry visible combinationally, 1-cycle push-to-visible.
// Push is dropped when full (full comes from the registered count, so a same-cycle pop does not help).
module apb_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_din,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end
endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: queued commands -> SETUP/ACCESS transfers; push to PSEL 2 cycles, one-cycle rsp pulse.
// Backpressure only on the command side (cmd_ready=!full); optional APB_TIMEOUT_EN aborts stuck ACCESS.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);
  state_t                   r_state;
  logic                     r_psel;
  logic                     r_penable;
  logic                     r_pwrite;
  logic [ADDR_W-1:0]        r_paddr;
  logic [DATA_W-1:0]        r_pwdata;
  logic                     r_rsp_valid;
  logic                     r_rsp_write;
  logic [DATA_W-1:0]        r_rsp_rdata;

  cmd_t                     w_push_cmd;
  cmd_t                     w_head;
  logic                     w_full;
  logic                     w_empty;
  logic [$clog2(CMD_DEPTH):0] w_count;
  logic                     w_timeout;
  logic                     w_done;
  logic                     w_launch;

  assign w_push_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready  = !w_full;
  assign w_done     = PREADY || w_timeout;
  assign w_launch   = !w_empty && ((r_state == S_IDLE) || ((r_state == S_ACCESS) && w_done));
  assign busy       = (r_state != S_IDLE) || (w_count != '0);

  apb_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .i_push  (cmd_valid && cmd_ready),
    .i_din   (w_push_cmd),
    .i_pop   (w_launch),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_acc_cnt;
  logic          r_rsp_err;

  // r_acc_cnt holds the ACCESS cycles already spent, so the last allowed one sees TIMEOUT_CYCLES-1.
  assign w_timeout = (r_state == S_ACCESS) && !PREADY && (r_acc_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_acc_cnt <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_rsp_err <= w_timeout;
      if (r_state == S_SETUP)
        r_acc_cnt <= '0;
      else if ((r_state == S_ACCESS) && !w_done)
        r_acc_cnt <= r_acc_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
  assign rsp_err          = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= S_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_pwrite  <= w_head.write;
            r_paddr   <= w_head.addr;
            r_pwdata  <= w_head.write ? w_head.wdata : '0;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_write <= r_pwrite;
            r_rsp_rdata <= (r_pwrite || w_timeout) ? '0 : PRDATA;
            r_penable   <= 1'b0;
            // Back-to-back: keep PSEL high and go straight to the next SETUP.
            if (!w_empty) begin
              r_pwrite <= w_head.write;
              r_paddr  <= w_head.addr;
              r_pwdata <= w_head.write ? w_head.wdata : '0;
              r_state  <= S_SETUP;
            end else begin
              r_psel  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: scenario tasks plus a completer/scoreboard process that models the
// bridge as an ordered command queue feeding APB transfers; build with APB_TIMEOUT_EN for the abort path.
module tb_apb_master_bridge;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid, rsp_write, rsp_err, busy;
  logic [7:0] rsp_rdata;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic [7:0] PRDATA = 8'h00;
  logic       PREADY = 1'b0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Completer knobs driven by the scenario tasks.
  bit         stall = 1'b0;
  int         fixed_wait = 0;   // -1 selects random 0..3 wait states
  bit         force_rd = 1'b0;
  logic [7:0] forced_rd = 8'h00;

  typedef struct packed {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
  } xfer_t;

  xfer_t      exp_q[$];
  xfer_t      last_x = '0;
  int         n_queued = 0;
  int         n_acc = 0;
  int         n_rsp = 0;
  bit         rsp_due = 1'b0;
  logic       rsp_w = 1'b0;
  logic [7:0] rsp_d = 8'h00;
  logic       rsp_e = 1'b0;
  int         acc_cyc = 0;
  int         wait_tgt = 0;
  bit         prev_ready = 1'b1;
  bit         expect_access = 1'b0;

  // Completer + scoreboard: samples 1 time unit after each edge, then drives PREADY/PRDATA.
  initial begin : completer
    forever begin
      @(posedge PCLK); #1;
      if (PRESET) begin
        exp_q.delete();
        n_queued = 0; rsp_due = 1'b0; acc_cyc = 0; prev_ready = 1'b1;
        expect_access = 1'b0; last_x = '0; PREADY = 1'b0;
      end else begin
        if (cmd_valid && prev_ready) begin
          exp_q.push_back(xfer_t'({cmd_write, cmd_addr, cmd_write ? cmd_wdata : 8'h00}));
          n_queued++; n_acc++;
        end
        if (PSEL && !PENABLE) begin
          n_queued--; acc_cyc = 0;
          wait_tgt = (fixed_wait < 0) ? int'($urandom_range(0, 3)) : fixed_wait;
        end
        n_cmp++;
        if (expect_access !== (PSEL && PENABLE) || (PENABLE && !PSEL))
          begin n_err++; $display("FAIL phase: PSEL=%b PENABLE=%b expected_access=%b", PSEL, PENABLE, expect_access); end
        n_cmp++;
        if (PSEL) begin
          if (exp_q.size() == 0)
            begin n_err++; $display("FAIL unexpected_xfer: PADDR=%h with no command queued", PADDR); end
          else if ({PWRITE, PADDR, PWDATA} !== exp_q[0])
            begin n_err++; $display("FAIL bus_fields: got %h expected %h", {PWRITE, PADDR, PWDATA}, exp_q[0]); end
        end else if ({PWRITE, PADDR, PWDATA} !== last_x)
          begin n_err++; $display("FAIL idle_hold: got %h expected %h", {PWRITE, PADDR, PWDATA}, last_x); end
        n_cmp++;
        if (rsp_due) begin
          n_rsp++;
          if (rsp_valid !== 1'b1 || rsp_write !== rsp_w || rsp_rdata !== rsp_d || rsp_err !== rsp_e)
            begin n_err++; $display("FAIL rsp: got v=%b w=%b d=%h e=%b expected v=1 w=%b d=%h e=%b",
                                    rsp_valid, rsp_write, rsp_rdata, rsp_err, rsp_w, rsp_d, rsp_e); end
        end else if (rsp_valid !== 1'b0)
          begin n_err++; $display("FAIL rsp_spurious: rsp_valid=%b expected 0", rsp_valid); end
        rsp_due = 1'b0;
        n_cmp++;
        if (cmd_ready !== (n_queued < DEPTH))
          begin n_err++; $display("FAIL cmd_ready: got %b expected %b (queued %0d)", cmd_ready, n_queued < DEPTH, n_queued); end
        n_cmp++;
        if (busy !== (PSEL || n_queued != 0))
          begin n_err++; $display("FAIL busy: got %b expected %b", busy, PSEL || n_queued != 0); end

        expect_access = PSEL && !PENABLE;
        PRDATA = force_rd ? forced_rd : 8'($urandom);
        PREADY = 1'($urandom);
        if (PSEL && PENABLE) begin
          acc_cyc++;
          PREADY = !stall && (acc_cyc > wait_tgt);
          if (PREADY) begin
            if (exp_q.size() != 0) last_x = exp_q.pop_front();
            rsp_due = 1'b1; rsp_w = last_x.w; rsp_d = last_x.w ? 8'h00 : PRDATA; rsp_e = 1'b0;
          end
`ifdef APB_TIMEOUT_EN
          else if (acc_cyc == TMO) begin
            if (exp_q.size() != 0) last_x = exp_q.pop_front();
            rsp_due = 1'b1; rsp_w = last_x.w; rsp_d = 8'h00; rsp_e = 1'b1;
          end
`endif
          else expect_access = 1'b1;
        end
        prev_ready = cmd_ready;
      end
    end
  end

  task automatic tick();
    @(posedge PCLK); #2;
  endtask

  task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push_wait(input logic w, input logic [7:0] a, input logic [7:0] d);
    int k = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && k < 200) begin tick(); k++; end
    tick();
    cmd_valid = 1'b0;
    n_cmp++;
    if (k >= 200) begin n_err++; $display("FAIL push_timeout: cmd_ready stuck 0 for %0d cycles", k); end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 500) begin tick(); k++; end
    tick(); tick();
    n_cmp++;
    if (k >= 500) begin n_err++; $display("FAIL idle_timeout: busy=%b after %0d cycles", busy, k); end
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #2;
    n_cmp++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin n_err++; $display("FAIL reset_ctrl: got %b expected 000", {PSEL, PENABLE, PWRITE}); end
    n_cmp++; if ({PADDR, PWDATA} !== 16'h0000) begin n_err++; $display("FAIL reset_bus: got %h expected 0000", {PADDR, PWDATA}); end
    n_cmp++; if ({rsp_valid, rsp_write, rsp_err, busy} !== 4'b0000) begin n_err++; $display("FAIL reset_rsp: got %b expected 0000", {rsp_valid, rsp_write, rsp_err, busy}); end
    n_cmp++; if (rsp_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h expected 00", rsp_rdata); end
    PRESET = 1'b0;
    tick();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_single_write();
    fixed_wait = 0; stall = 1'b0;
    push(1'b1, 8'h04, 8'hA5);
    n_cmp++; if (PSEL !== 1'b0) begin n_err++; $display("FAIL sw_early: PSEL=%b expected 0 one cycle after push", PSEL); end
    tick();
    n_cmp++; if ({PSEL, PENABLE} !== 2'b10) begin n_err++; $display("FAIL sw_setup: PSEL/PENABLE=%b expected 10", {PSEL, PENABLE}); end
    n_cmp++; if ({PWRITE, PADDR, PWDATA} !== 17'h104A5) begin n_err++; $display("FAIL sw_fields: got %h expected 104a5", {PWRITE, PADDR, PWDATA}); end
    tick();
    n_cmp++; if ({PSEL, PENABLE, PWDATA} !== 10'h3A5) begin n_err++; $display("FAIL sw_access: got %h expected 3a5", {PSEL, PENABLE, PWDATA}); end
    tick();
    n_cmp++; if ({rsp_valid, rsp_write, rsp_rdata, PSEL} !== 11'b11_00000000_0) begin n_err++; $display("FAIL sw_rsp: v=%b w=%b d=%h psel=%b expected 1 1 00 0", rsp_valid, rsp_write, rsp_rdata, PSEL); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL sw_pulse: rsp_valid=%b expected 0", rsp_valid); end
  endtask

  task automatic test_read_wait();
    int en_cnt = 0;
    bit got = 1'b0;
    logic       got_w = 1'b1;
    logic [7:0] got_d = 8'h00;
    fixed_wait = 3; force_rd = 1'b1; forced_rd = 8'h3C;
    push(1'b0, 8'h0C, 8'hFF);
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (PENABLE) en_cnt++;
      if (rsp_valid) begin got = 1'b1; got_w = rsp_write; got_d = rsp_rdata; end
    end
    n_cmp++; if (en_cnt != 4) begin n_err++; $display("FAIL rw_penable: held %0d cycles expected 4", en_cnt); end
    n_cmp++; if ({got, got_w, got_d} !== {1'b1, 1'b0, 8'h3C}) begin n_err++; $display("FAIL rw_rsp: got=%b w=%b d=%h expected 1 0 3c", got, got_w, got_d); end
    force_rd = 1'b0; fixed_wait = 0;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int rsp_cnt = 0, gaps = 0, setups = 0, base = n_rsp;
    logic [4:0] dirs = 5'b0;
    stall = 1'b1; fixed_wait = 0;
    push(1'b1, 8'h10, 8'h5A);
    tick(); tick();
    n_cmp++; if (PENABLE !== 1'b1) begin n_err++; $display("FAIL b2b_stalled: PENABLE=%b expected 1", PENABLE); end
    push(1'b1, 8'h00, 8'h00);
    push(1'b1, 8'h00, 8'h11);
    push(1'b1, 8'h00, 8'h22);
    push(1'b0, 8'h08, 8'h00);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full: cmd_ready=%b expected 0", cmd_ready); end
    push(1'b1, 8'hEE, 8'hEE);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_refused: cmd_ready=%b expected 0", cmd_ready); end
    stall = 1'b0;
    for (int i = 0; i < 40 && rsp_cnt < 5; i++) begin
      tick();
      if (rsp_valid) begin dirs[4 - rsp_cnt] = rsp_write; rsp_cnt++; end
      if (PSEL && !PENABLE) setups++;
      if (rsp_cnt < 5 && !PSEL) gaps++;
    end
    n_cmp++; if (rsp_cnt != 5) begin n_err++; $display("FAIL b2b_count: %0d responses expected 5", rsp_cnt); end
    n_cmp++; if (gaps != 0 || setups != 4) begin n_err++; $display("FAIL b2b_psel: %0d PSEL gaps, %0d setups expected 0 and 4", gaps, setups); end
    n_cmp++; if (dirs !== 5'b11110) begin n_err++; $display("FAIL b2b_order: directions %b expected 11110", dirs); end
    wait_idle();
    n_cmp++; if (n_rsp - base != 5) begin n_err++; $display("FAIL b2b_scoreboard: %0d responses expected 5", n_rsp - base); end
  endtask

  task automatic test_wrap();
    int base = n_rsp;
    stall = 1'b1; fixed_wait = 0;
    push(1'b1, 8'h30, 8'h01);
    tick(); tick();
    for (int i = 0; i < DEPTH - 1; i++) push(1'b1, 8'(8'h40 + i), 8'($urandom));
    stall = 1'b0;
    for (int i = 0; i < 2 * DEPTH; i++) push_wait(1'($urandom), 8'($urandom), 8'($urandom));
    wait_idle();
    n_cmp++; if (n_rsp - base != 3 * DEPTH) begin n_err++; $display("FAIL wrap_count: %0d responses expected %0d", n_rsp - base, 3 * DEPTH); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL wrap_drain: %0d commands left expected 0", exp_q.size()); end
  endtask

  task automatic test_random();
    int base = n_rsp;
    fixed_wait = -1; stall = 1'b0;
    for (int i = 0; i < 40; i++) begin
      push_wait(1'($urandom), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle();
    n_cmp++; if (n_rsp - base != 40) begin n_err++; $display("FAIL rand_count: %0d responses expected 40", n_rsp - base); end
    fixed_wait = 0;
  endtask

  task automatic test_stall_reset();
`ifdef APB_TIMEOUT_EN
    int en_cnt = 0;
    bit got = 1'b0;
    logic [9:0] got_f = '0;
    stall = 1'b1; fixed_wait = 0;
    push(1'b0, 8'h0C, 8'h00);
    push(1'b1, 8'h20, 8'h77);
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (PENABLE) en_cnt++;
      if (rsp_valid) begin got = 1'b1; got_f = {rsp_write, rsp_err, rsp_rdata}; end
    end
    stall = 1'b0;
    n_cmp++; if (en_cnt != TMO) begin n_err++; $display("FAIL tmo_cycles: PENABLE held %0d expected %0d", en_cnt, TMO); end
    n_cmp++; if (got_f !== {1'b0, 1'b1, 8'h00}) begin n_err++; $display("FAIL tmo_rsp: w/e/d=%h expected 100", got_f); end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (rsp_valid) begin got = 1'b1; got_f = {rsp_write, rsp_err, rsp_rdata}; end
    end
    n_cmp++; if ({got, got_f} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin n_err++; $display("FAIL tmo_next: got=%b w/e/d=%h expected 1 200", got, got_f); end
    wait_idle();
    stall = 1'b1;
    push(1'b0, 8'h0C, 8'h00);
    push(1'b1, 8'h21, 8'h55);
    tick();
`else
    stall = 1'b1; fixed_wait = 0;
    push(1'b0, 8'h0C, 8'h00);
    push(1'b1, 8'h20, 8'h77);
    repeat (110) tick();
    n_cmp++; if ({PSEL, PENABLE} !== 2'b11) begin n_err++; $display("FAIL hold_forever: PSEL/PENABLE=%b expected 11 after 110 cycles", {PSEL, PENABLE}); end
`endif
    n_cmp++; if ({PENABLE, PREADY} !== 2'b10) begin n_err++; $display("FAIL rst_pre: PENABLE/PREADY=%b expected 10", {PENABLE, PREADY}); end
    PRESET = 1'b1;
    #1;
    n_cmp++; if ({PSEL, PENABLE} !== 2'b00) begin n_err++; $display("FAIL rst_async: PSEL/PENABLE=%b expected 00", {PSEL, PENABLE}); end
    tick();
    PRESET = 1'b0; stall = 1'b0;
    tick();
    n_cmp++; if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin n_err++; $display("FAIL rst_after: ready/busy/rsp=%b expected 100", {cmd_ready, busy, rsp_valid}); end
    repeat (6) tick();
    n_cmp++; if ({PSEL, busy} !== 2'b00) begin n_err++; $display("FAIL rst_dropped: PSEL/busy=%b expected 00", {PSEL, busy}); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_back_to_back();
    test_wrap();
    test_random();
    test_stall_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched so far", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end
endmodule
